// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, spawn clipping, LFSR taps and the
// encoding of the spawn handshake states.
package game_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int ENEMY_SIZE = 20;

    // A spawn must fit fully on screen, so coordinates are clipped one enemy short of the edge.
    localparam logic [9:0] X_CLIP = 10'(SCREEN_W - ENEMY_SIZE);
    localparam logic [8:0] Y_CLIP = 9'(SCREEN_H - ENEMY_SIZE);
    localparam logic [9:0] X_SUB  = 10'd512;
    localparam logic [8:0] Y_SUB  = 9'd256;

    localparam int LFSR_TAP_A = 9;
    localparam int LFSR_TAP_B = 6;

    localparam logic [1:0] H_IDLE      = 2'd0;
    localparam logic [1:0] H_WAIT_ACK  = 2'd1;
    localparam logic [1:0] H_WAIT_NACK = 2'd2;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } spawn_t;

    localparam int ENTRY_W = $bits(spawn_t);

    function automatic logic [9:0] lfsr_next(input logic [9:0] l);
        return {l[8:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B]};
    endfunction

    function automatic spawn_t map_spawn(input logic [9:0] l);
        logic [8:0] y_raw;
        spawn_t     s;
        y_raw = {l[3:0], l[9:5]};
        s.x   = (l >= X_CLIP) ? l - X_SUB : l;
        s.y   = (y_raw >= Y_CLIP) ? y_raw - Y_SUB : y_raw;
        return s;
    endfunction

endpackage

// File: rtl/spawn_fifo.sv
// Synchronous FIFO for pending spawn entries; asynchronous active-high reset.
module spawn_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic                     clk_1Hz,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Wave timer and spawn producer: generates per-wave LFSR spawn bursts, queues
// them, and hands them to the faster enemy engine over a four-phase req/ack link.
module enemy_wave_scheduler
    import game_pkg::*;
#(
    parameter int         WAVE_PERIOD = 10,
    parameter int         BASE_COUNT  = 2,
    parameter int         MAX_COUNT   = 8,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [9:0] LFSR_SEED   = 10'h280
) (
    input  logic                          clk_1Hz,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          spawn_ack,
    output logic                          spawn_req,
    output logic [9:0]                    spawn_x,
    output logic [8:0]                    spawn_y,
    output logic [7:0]                    wave,
    output logic [7:0]                    sec_left,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic [1:0]                    hs_state
);

    logic [9:0] lfsr;
    logic [7:0] burst_left;
    logic [7:0] wave_next;
    logic [8:0] burst_sum;
    logic [7:0] burst_reload;
    logic       ack_meta;
    logic       ack_sync;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    spawn_t     new_entry;
    spawn_t     head;

    assign new_entry    = map_spawn(lfsr);
    assign wave_next    = (wave == 8'hFF) ? wave : wave + 8'd1;
    assign burst_sum    = 9'(BASE_COUNT) + {1'b0, wave_next};
    assign burst_reload = (burst_sum >= 9'(MAX_COUNT)) ? 8'(MAX_COUNT) : burst_sum[7:0];
    assign push         = enable && (sec_left != 8'd0) && (burst_left != 8'd0) && !fifo_full;
    assign pop          = (hs_state == H_IDLE) && !fifo_empty;

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_next(lfsr);
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= spawn_ack;
            ack_sync <= ack_meta;
        end
    end

    // The rollover tick never pushes; a burst still unqueued at rollover is lost and flagged.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            wave       <= 8'd0;
            sec_left   <= 8'(WAVE_PERIOD - 1);
            burst_left <= 8'(BASE_COUNT);
            overrun    <= 1'b0;
        end else if (enable) begin
            if (sec_left == 8'd0) begin
                wave       <= wave_next;
                sec_left   <= 8'(WAVE_PERIOD - 1);
                burst_left <= burst_reload;
                if (burst_left != 8'd0) overrun <= 1'b1;
            end else begin
                sec_left <= sec_left - 8'd1;
                if (push) burst_left <= burst_left - 8'd1;
            end
        end
    end

    spawn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .push    (push),
        .wr_data (new_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Four-phase link: spawn_req rises with spawn_x/spawn_y already valid and holds them
    // until the synchronized ack is seen high; req then drops, and a new req is only
    // raised after the synchronized ack has returned low.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            hs_state  <= H_IDLE;
            spawn_req <= 1'b0;
            spawn_x   <= 10'd0;
            spawn_y   <= 9'd0;
        end else begin
            case (hs_state)
                H_IDLE: begin
                    if (pop) begin
                        spawn_x   <= head.x;
                        spawn_y   <= head.y;
                        spawn_req <= 1'b1;
                        hs_state  <= H_WAIT_ACK;
                    end
                end
                H_WAIT_ACK: begin
                    if (ack_sync) begin
                        spawn_req <= 1'b0;
                        hs_state  <= H_WAIT_NACK;
                    end
                end
                H_WAIT_NACK: begin
                    if (!ack_sync) hs_state <= H_IDLE;
                end
                default: begin
                    spawn_req <= 1'b0;
                    hs_state  <= H_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Directed bench for enemy_wave_scheduler: a scripted consumer, a spawn
// scoreboard and hand-derived tick-by-tick expectations.
module tb_enemy_wave_scheduler;

    logic       clk_1Hz = 1'b0;
    logic       rst;
    logic       enable;
    logic       spawn_ack;
    logic       spawn_req;
    logic [9:0] spawn_x;
    logic [8:0] spawn_y;
    logic [7:0] wave;
    logic [7:0] sec_left;
    logic [2:0] fifo_count;
    logic       overrun;
    logic [1:0] hs_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [18:0] exp_q[$];
    int          cons_mode;
    int          hold_cnt;
    int          viol;
    bit          sb_on;

    localparam int HOLD = 8;

    enemy_wave_scheduler dut (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .enable     (enable),
        .spawn_ack  (spawn_ack),
        .spawn_req  (spawn_req),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .wave       (wave),
        .sec_left   (sec_left),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .hs_state   (hs_state)
    );

    // clock / watchdog
    always #5 clk_1Hz = ~clk_1Hz;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference spawn entry produced from the n-th LFSR state after reset.
    function automatic logic [18:0] entry_at(input int n);
        logic [9:0] l;
        logic [9:0] x;
        logic [8:0] yr;
        logic [8:0] y;
        l = 10'h280;
        for (int i = 0; i < n; i++) l = {l[8:0], l[9] ^ l[6]};
        x  = (l >= 10'd620) ? l - 10'd512 : l;
        yr = {l[3:0], l[9:5]};
        y  = (yr >= 9'd460) ? yr - 9'd256 : yr;
        return {x, y};
    endfunction

    task automatic record_spawn();
        logic [18:0] got;
        got = {spawn_x, spawn_y};
        if (sb_on) begin
            if (exp_q.size() == 0) check("spawn_unexpected", 32'(exp_q.size()), 1);
            else                   check("spawn_entry", 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // consumer driver: 0 = never ack, 1 = immediate four-phase, 2 = ack held high HOLD ticks
    task automatic consumer_step();
        case (cons_mode)
            1: begin
                if (spawn_req && !spawn_ack) begin
                    record_spawn();
                    spawn_ack = 1'b1;
                end else if (!spawn_req && spawn_ack) begin
                    spawn_ack = 1'b0;
                end
            end
            2: begin
                if (spawn_req && spawn_ack && hold_cnt > 0) viol++;
                if (spawn_req && !spawn_ack) begin
                    record_spawn();
                    spawn_ack = 1'b1;
                    hold_cnt  = 0;
                end else if (!spawn_req && spawn_ack) begin
                    hold_cnt++;
                    if (hold_cnt >= HOLD) spawn_ack = 1'b0;
                end
            end
            default: spawn_ack = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
        consumer_step();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        spawn_ack = 1'b0;
        cons_mode = 0;
        sb_on     = 1'b0;
        hold_cnt  = 0;
        viol      = 0;
        exp_q.delete();
        #2;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        do_reset();
        check("rst_req", spawn_req, 0);
        check("rst_x", spawn_x, 0);
        check("rst_y", spawn_y, 0);
        check("rst_wave", wave, 0);
        check("rst_sec", sec_left, 9);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", hs_state, 0);

        // first spawns and first wave rollover with an immediate consumer
        cons_mode = 1;
        sb_on     = 1'b1;
        exp_q.push_back({10'd128, 9'd20});
        exp_q.push_back({10'd257, 9'd40});
        exp_q.push_back(entry_at(10));
        exp_q.push_back(entry_at(11));
        exp_q.push_back(entry_at(12));
        enable = 1'b1;
        tick();
        check("t1_count", fifo_count, 1);
        check("t1_req", spawn_req, 0);
        tick();
        check("t2_req", spawn_req, 1);
        check("t2_x", spawn_x, 128);
        check("t2_y", spawn_y, 20);
        check("t2_count", fifo_count, 1);
        check("t2_state", hs_state, 1);
        tick(); tick();
        check("t4_req_held", spawn_req, 1);
        tick();
        check("t5_req_fall", spawn_req, 0);
        check("t5_state", hs_state, 2);
        tick(); tick(); tick();
        check("t8_state", hs_state, 0);
        tick();
        check("t9_req", spawn_req, 1);
        check("t9_x", spawn_x, 257);
        check("t9_y", spawn_y, 40);
        check("t9_count", fifo_count, 0);
        check("t9_sec", sec_left, 0);
        check("t9_wave", wave, 0);
        tick();
        check("t10_wave", wave, 1);
        check("t10_sec", sec_left, 9);
        check("t10_overrun", overrun, 0);
        tick();
        check("t11_count", fifo_count, 1);
        tick();
        check("t12_count", fifo_count, 2);
        tick();
        check("t13_count", fifo_count, 3);
        wait_drain("first_drain", 40);
        sb_on = 1'b0;

        // backpressure: ack held low
        do_reset();
        enable = 1'b1;
        repeat (2) tick();
        check("bp_req", spawn_req, 1);
        repeat (23) tick();
        check("bp_count_full", fifo_count, 4);
        check("bp_req_held", spawn_req, 1);
        check("bp_x_stable", spawn_x, 128);
        check("bp_y_stable", spawn_y, 20);
        check("bp_overrun_pre", overrun, 0);
        repeat (5) tick();
        check("bp_overrun", overrun, 1);
        check("bp_wave", wave, 3);
        exp_q.push_back(entry_at(0));
        exp_q.push_back(entry_at(1));
        exp_q.push_back(entry_at(10));
        exp_q.push_back(entry_at(11));
        exp_q.push_back(entry_at(12));
        sb_on     = 1'b1;
        cons_mode = 1;
        wait_drain("bp_drain", 60);
        check("bp_overrun_sticky", overrun, 1);
        sb_on = 1'b0;

        // pause: timer freezes, handshake keeps draining
        do_reset();
        cons_mode = 1;
        sb_on     = 1'b1;
        exp_q.push_back(entry_at(0));
        exp_q.push_back(entry_at(1));
        enable = 1'b1;
        repeat (4) tick();
        check("pause_sec_start", sec_left, 5);
        enable = 1'b0;
        repeat (7) tick();
        check("pause_sec_hold", sec_left, 5);
        check("pause_wave_hold", wave, 0);
        check("pause_drain", 32'(exp_q.size()), 0);
        enable = 1'b1;
        tick();
        check("pause_resume_sec", sec_left, 4);
        sb_on = 1'b0;

        // asynchronous reset in the middle of a handshake
        do_reset();
        enable = 1'b1;
        repeat (2) tick();
        check("ar_req_before", spawn_req, 1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_req", spawn_req, 0);
        check("ar_x", spawn_x, 0);
        check("ar_y", spawn_y, 0);
        check("ar_sec", sec_left, 9);
        check("ar_count", fifo_count, 0);
        @(posedge clk_1Hz);
        #1;
        rst       = 1'b0;
        cons_mode = 1;
        sb_on     = 1'b1;
        exp_q.push_back({10'd128, 9'd20});
        repeat (2) tick();
        check("ar_first_req", spawn_req, 1);
        check("ar_first_x", spawn_x, 128);
        check("ar_first_y", spawn_y, 20);
        wait_drain("ar_drain", 10);
        sb_on = 1'b0;

        // ack held high across entries: no new req until the ack is seen low
        do_reset();
        cons_mode = 2;
        sb_on     = 1'b1;
        exp_q.push_back(entry_at(0));
        exp_q.push_back(entry_at(1));
        enable = 1'b1;
        wait_drain("glitch_drain", 40);
        check("glitch_no_req_while_ack", 32'(viol), 0);
        sb_on = 1'b0;

        // wave counter saturation
        do_reset();
        enable = 1'b1;
        repeat (2540) tick();
        check("sat_wave_254", wave, 254);
        repeat (20) tick();
        check("sat_wave_255", wave, 255);
        check("sat_sec", sec_left, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
